frame_capture: RTL and testbench

FRAME_CAPTURE -- requirements
Module: frame_capture

---
 rtl/frame_capture.sv | 132 +++++++++++++
 tb/tb_frame_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture.sv
// Frame capture controller: arms on request, counts one frame of upstream words into a
// first-word-fall-through FIFO and streams them out. Define FRAME_CAPTURE_HDR_EN to add a header word.
module frame_capture #(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_arm,
  input  logic        i_abort,
  input  logic [15:0] i_frame_len,
  input  logic [31:0] i_in_data,
  input  logic        i_in_vld,
  output logic        o_sync,
  output logic        o_complite,
  output logic [31:0] o_rd_data,
  output logic        o_rd_vld,
  input  logic        i_rd_rdy,
  output logic        o_busy,
  output logic        o_overflow,
  output logic [15:0] o_word_cnt
);

  localparam int unsigned Depth = 2 ** FIFO_AW;

  typedef enum logic [1:0] {StIdle, StSync, StCapture, StFlush} state_e;

  state_e             state_q, state_d;
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]        mem_q [Depth];
  logic [15:0]        len_q, len_d, cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               empty, full, push_req, push, pop, flush;
  logic [31:0]        push_data;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    push_req   = 1'b0;
    push_data  = i_in_data;
    flush      = 1'b0;
    o_sync     = 1'b0;
    o_complite = 1'b0;
    if (i_abort) begin
      // Abort in SYNC reports only the stop pulse so sync/complite never overlap.
      state_d    = StIdle;
      flush      = 1'b1;
      o_complite = (state_q == StSync) || (state_q == StCapture);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_arm) begin
            state_d = StSync;
            len_d   = (i_frame_len == 16'd0) ? 16'd1 : i_frame_len;
            cnt_d   = 16'd0;
          end
        end
        StSync: begin
          o_sync  = 1'b1;
          state_d = StCapture;
`ifdef FRAME_CAPTURE_HDR_EN
          push_req  = 1'b1;
          push_data = {16'hA55A, len_q};
`endif
        end
        StCapture: begin
          if (i_in_vld) begin
            push_req = 1'b1;
            cnt_d    = cnt_q + 16'd1;
            if (cnt_d == len_q) begin
              o_complite = 1'b1;
              state_d    = StFlush;
            end
          end
        end
        StFlush: begin
          if (empty) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Full is judged before any same-cycle pop, so a write into a full FIFO drops.
  assign push = push_req && !full;
  assign pop  = !empty && i_rd_rdy;

  always_comb begin
    ovf_d = ovf_q;
    if (!i_abort && state_q == StIdle && i_arm) ovf_d = 1'b0;
    if (push_req && full) ovf_d = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
    if (flush) rd_ptr_d = wr_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= 16'd1;
      cnt_q    <= 16'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data;
  end

  assign o_rd_vld   = !empty;
  assign o_rd_data  = empty ? 32'd0 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign o_busy     = (state_q != StIdle);
  assign o_overflow = ovf_q;
  assign o_word_cnt = cnt_q;

endmodule

// File: tb/tb_frame_capture.sv
// Bench for frame_capture: a queue-based frame model checked every cycle plus directed
// scenarios with literal expectations.
module tb_frame_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_arm = 1'b0, i_abort = 1'b0, i_in_vld = 1'b0, i_rd_rdy = 1'b0;
  logic [15:0] i_frame_len = 16'd0;
  logic [31:0] i_in_data = 32'd0;
  logic        o_sync, o_complite, o_rd_vld, o_busy, o_overflow;
  logic [31:0] o_rd_data;
  logic [15:0] o_word_cnt;

  int checks = 0;
  int errors = 0;

`ifdef FRAME_CAPTURE_HDR_EN
  localparam int Hdr = 1;
`else
  localparam int Hdr = 0;
`endif

  frame_capture #(.FIFO_AW(4)) dut (
    .clk(clk), .rst(rst), .i_arm(i_arm), .i_abort(i_abort), .i_frame_len(i_frame_len),
    .i_in_data(i_in_data), .i_in_vld(i_in_vld), .o_sync(o_sync), .o_complite(o_complite),
    .o_rd_data(o_rd_data), .o_rd_vld(o_rd_vld), .i_rd_rdy(i_rd_rdy), .o_busy(o_busy),
    .o_overflow(o_overflow), .o_word_cnt(o_word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 sync, 2 capture, 3 flush; queue holds buffered words.
  int          m_ph = 0;
  logic [31:0] m_q[$];
  logic [15:0] m_len = 16'd1, m_cnt = 16'd0;
  logic        m_ovf = 1'b0;

  // Monitor logs, only ever written by the compare process.
  logic [31:0] rd_log[$];
  int          sent_n = 0, comp_n = 0, comp_at = 0, sync_n = 0;

  initial forever begin
    logic e_sync, e_comp, e_vld, full, pop;
    logic [31:0] e_data;
    @(negedge clk);
    if (rst) begin
      m_ph = 0; m_q.delete(); m_cnt = 16'd0; m_ovf = 1'b0;
    end
    e_sync = (m_ph == 1) && !i_abort;
    e_comp = i_abort ? (m_ph == 1 || m_ph == 2)
                     : (m_ph == 2 && i_in_vld && (m_cnt + 16'd1 == m_len));
    e_vld  = (m_q.size() != 0);
    e_data = e_vld ? m_q[0] : 32'd0;
    chk("sync", {31'd0, o_sync}, {31'd0, e_sync});
    chk("complite", {31'd0, o_complite}, {31'd0, e_comp});
    chk("rd_vld", {31'd0, o_rd_vld}, {31'd0, e_vld});
    chk("rd_data", o_rd_data, e_data);
    chk("busy", {31'd0, o_busy}, {31'd0, (m_ph != 0)});
    chk("overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
    chk("word_cnt", {16'd0, o_word_cnt}, {16'd0, m_cnt});
    if (!rst) begin
      if (i_in_vld) sent_n++;
      if (o_sync) sync_n++;
      if (o_complite) begin comp_n++; comp_at = sent_n; end
      if (o_rd_vld && i_rd_rdy) rd_log.push_back(o_rd_data);
      full = (m_q.size() >= 16);
      pop  = e_vld && i_rd_rdy;
      if (pop) void'(m_q.pop_front());
      if (i_abort) begin
        m_ph = 0; m_q.delete();
      end else begin
        case (m_ph)
          0: if (i_arm) begin
               m_ph = 1; m_len = (i_frame_len == 0) ? 16'd1 : i_frame_len;
               m_cnt = 16'd0; m_ovf = 1'b0;
             end
          1: begin
               if (Hdr == 1) begin
                 if (full) m_ovf = 1'b1; else m_q.push_back({16'hA55A, m_len});
               end
               m_ph = 2;
             end
          2: if (i_in_vld) begin
               if (full) m_ovf = 1'b1; else m_q.push_back(i_in_data);
               m_cnt = m_cnt + 16'd1;
               if (m_cnt == m_len) m_ph = 3;
             end
          default: if (!e_vld) m_ph = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    i_arm = 1'b0; i_abort = 1'b0; i_in_vld = 1'b0;
  endtask

  task automatic arm(input logic [15:0] len);
    i_arm = 1'b1; i_frame_len = len; tick(); tick();
  endtask

  task automatic send(input logic [31:0] d);
    i_in_vld = 1'b1; i_in_data = d; tick();
  endtask

  task automatic drain();
    int n = 0;
    i_rd_rdy = 1'b1;
    while (o_busy && n < 100) begin tick(); n++; end
    if (o_busy) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int b_log, b_comp, b_sent, b_sync;
    tick(); tick();
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_rd_vld", {31'd0, o_rd_vld}, 32'd0);
    rst = 1'b0; tick();

    // Basic frame, reader always ready.
    b_log = rd_log.size(); b_comp = comp_n; b_sent = sent_n; b_sync = sync_n;
    i_rd_rdy = 1'b1;
    arm(16'd4);
    send(32'h11); send(32'h22); send(32'h33); send(32'h44);
    drain();
    chk("s1_sync_n", sync_n - b_sync, 32'd1);
    chk("s1_comp_n", comp_n - b_comp, 32'd1);
    chk("s1_comp_at", comp_at - b_sent, 32'd4);
    chk("s1_rd0", rd_log[b_log + Hdr + 0], 32'h11);
    chk("s1_rd1", rd_log[b_log + Hdr + 1], 32'h22);
    chk("s1_rd2", rd_log[b_log + Hdr + 2], 32'h33);
    chk("s1_rd3", rd_log[b_log + Hdr + 3], 32'h44);
    chk("s1_busy", {31'd0, o_busy}, 32'd0);

    // Overflow: reader stalled, 20 words into a 16-deep FIFO.
    b_log = rd_log.size(); b_comp = comp_n; b_sent = sent_n;
    i_rd_rdy = 1'b0;
    arm(16'd20);
    for (int i = 0; i < 20; i++) send(32'h100 + i);
    chk("s2_ovf", {31'd0, o_overflow}, 32'd1);
    chk("s2_cnt", {16'd0, o_word_cnt}, 32'd20);
    chk("s2_comp_at", comp_at - b_sent, 32'd20);
    chk("s2_comp_n", comp_n - b_comp, 32'd1);
    drain();
    chk("s2_stored", rd_log.size() - b_log, 32'd16);
    chk("s2_last", rd_log[rd_log.size() - 1], 32'h10F - Hdr);

    // Abort after three words.
    b_comp = comp_n;
    arm(16'd10);
    send(32'hA1); send(32'hA2); send(32'hA3);
    i_abort = 1'b1; i_arm = 1'b1; tick();
    chk("s3_comp_n", comp_n - b_comp, 32'd1);
    chk("s3_rd_vld", {31'd0, o_rd_vld}, 32'd0);
    chk("s3_busy", {31'd0, o_busy}, 32'd0);
    chk("s3_cnt", {16'd0, o_word_cnt}, 32'd3);
    chk("s3_ovf_cleared", {31'd0, o_overflow}, 32'd0);

    // Zero length behaves as one word.
    b_comp = comp_n; b_sent = sent_n;
    arm(16'd0);
    send(32'hBEEF);
    chk("s4_comp_at", comp_at - b_sent, 32'd1);
    chk("s4_cnt", {16'd0, o_word_cnt}, 32'd1);
    drain();

    // Reset mid-capture with five words buffered.
    b_comp = comp_n;
    i_rd_rdy = 1'b0;
    arm(16'd10);
    for (int i = 0; i < 5; i++) send(32'hC0 + i);
    rst = 1'b1; #1;
    chk("s5_busy", {31'd0, o_busy}, 32'd0);
    chk("s5_rd_vld", {31'd0, o_rd_vld}, 32'd0);
    chk("s5_rd_data", o_rd_data, 32'd0);
    chk("s5_cnt", {16'd0, o_word_cnt}, 32'd0);
    chk("s5_sync", {31'd0, o_sync}, 32'd0);
    chk("s5_complite", {31'd0, o_complite}, 32'd0);
    tick(); rst = 1'b0; tick();
    chk("s5_comp_n", comp_n - b_comp, 32'd0);

`ifdef FRAME_CAPTURE_HDR_EN
    b_log = rd_log.size();
    i_rd_rdy = 1'b1;
    arm(16'd2);
    send(32'hAB); send(32'hCD);
    drain();
    chk("s6_hdr", rd_log[b_log], 32'hA55A0002);
    chk("s6_d0", rd_log[b_log + 1], 32'hAB);
    chk("s6_d1", rd_log[b_log + 2], 32'hCD);
`endif

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
